// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback trace monitor: FSM state encoding
// and the width of the capture and idle counters.
package wb_trace_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

endpackage

// File: rtl/wb_trace_ram.sv
// Trace buffer storage: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module wb_trace_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_monitor.sv
// Captures writeback results into a circular trace buffer until EXPECT_CNT
// captures arrive or the bus idles for TIMEOUT_CYC cycles. Optional signature via WB_TRACE_SIGNATURE_EN.
module wb_trace_monitor
  import wb_trace_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned EXPECT_CNT  = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     wb_valid,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         cap_cnt,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic                     done,
`ifdef WB_TRACE_SIGNATURE_EN
  output logic [DATA_W-1:0]        sig,
`endif
  output logic                     timeout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = PW + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic              ram_we;
  logic [PW-1:0]     rd_phys;
  logic [DATA_W-1:0] ram_rdata;
`ifdef WB_TRACE_SIGNATURE_EN
  logic [DATA_W-1:0] sig_q, sig_d;
`endif

  always_comb begin
    state_d    = state_q;
    cap_cnt_d  = cap_cnt_q;
    idle_cnt_d = idle_cnt_q;
    fill_d     = fill_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    ram_we     = 1'b0;
`ifdef WB_TRACE_SIGNATURE_EN
    sig_d      = sig_q;
`endif
    if (start) begin
      state_d    = ST_RUN;
      cap_cnt_d  = '0;
      idle_cnt_d = '0;
      fill_d     = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
`ifdef WB_TRACE_SIGNATURE_EN
      sig_d      = '0;
`endif
    end else if (state_q == ST_RUN) begin
      if (wb_valid) begin
        ram_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PW'(1);
        idle_cnt_d = '0;
        if (cap_cnt_q != CNT_MAX) begin
          cap_cnt_d = cap_cnt_q + CNT_W'(1);
        end
        // A full buffer keeps its fill; the write lands on the oldest slot.
        if (fill_q == FW'(DEPTH)) begin
          overflow_d = 1'b1;
        end else begin
          fill_d = fill_q + FW'(1);
        end
`ifdef WB_TRACE_SIGNATURE_EN
        sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ wb_data;
`endif
        // Idle count never advances on a capture, so completion wins a tie.
        if (cap_cnt_d == CNT_W'(EXPECT_CNT)) begin
          state_d = ST_DONE;
        end
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
        if (idle_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          state_d = ST_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_cnt_q  <= '0;
      idle_cnt_q <= '0;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
`ifdef WB_TRACE_SIGNATURE_EN
      sig_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cap_cnt_q  <= cap_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      fill_q     <= fill_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
`ifdef WB_TRACE_SIGNATURE_EN
      sig_q      <= sig_d;
`endif
    end
  end

  // rd_addr 0 is the oldest retained entry, fill slots behind the write pointer.
  assign rd_phys = wr_ptr_q - fill_q[PW-1:0] + rd_addr;

  wb_trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wb_data),
    .raddr (rd_phys),
    .rdata (ram_rdata)
  );

  assign rd_data  = ({1'b0, rd_addr} < fill_q) ? ram_rdata : '0;
  assign state    = state_q;
  assign cap_cnt  = cap_cnt_q;
  assign fill     = fill_q;
  assign overflow = overflow_q;
  assign done     = (state_q == ST_DONE);
  assign timeout  = (state_q == ST_TIMEOUT);
`ifdef WB_TRACE_SIGNATURE_EN
  assign sig      = sig_q;
`endif

endmodule

// File: doc/wb_trace_monitor.md
WB_TRACE_MONITOR -- requirements
Module: wb_trace_monitor

Interface
REQ-001 Parameter DATA_W, default 32, width of the writeback result word.
REQ-002 Parameter DEPTH, default 16, trace buffer entries; power of two, at least 2.
REQ-003 Parameter EXPECT_CNT, default 8, captures needed to finish; range 1..65535.
REQ-004 Parameter TIMEOUT_CYC, default 64, idle RUN cycles before timeout; range 1..65535.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  clear all state and arm capture.
REQ-008 wb_valid  in  1  writeback result present this cycle.
REQ-009 wb_data  in  DATA_W  writeback result, e.g. the ALU_ResultW word.
REQ-010 rd_addr  in  log2(DEPTH)  read index; 0 selects the oldest retained entry.
REQ-011 rd_data  out  DATA_W  combinational read of the entry at rd_addr.
REQ-012 state  out  2  FSM state: IDLE=0, RUN=1, DONE=2, TIMEOUT=3.
REQ-013 cap_cnt  out  16  total captures since the last start; saturates at 65535.
REQ-014 fill  out  log2(DEPTH)+1  number of valid buffer entries, 0..DEPTH.
REQ-015 overflow  out  1  sticky flag: an entry was overwritten since the last start.
REQ-016 done  out  1  high while state is DONE.
REQ-017 timeout  out  1  high while state is TIMEOUT.

Function
REQ-018 FSM transitions SHALL be: any state to RUN on start; RUN to DONE on the capture that makes cap_cnt equal EXPECT_CNT; RUN to TIMEOUT when idle_cnt reaches TIMEOUT_CYC; DONE and TIMEOUT hold until start or rst.
REQ-019 start SHALL clear cap_cnt, fill, the write pointer, idle_cnt, overflow and (when compiled in) the signature; wb_valid in the start cycle SHALL NOT be captured.
REQ-020 In RUN, wb_valid SHALL write wb_data at the write pointer; the pointer then increments modulo DEPTH, and cap_cnt and fill each increment.
REQ-021 A capture while fill equals DEPTH SHALL overwrite the oldest entry, leave fill at DEPTH, and set overflow.
REQ-022 wb_valid SHALL be ignored in IDLE, DONE and TIMEOUT.
REQ-023 idle_cnt SHALL increment on each RUN cycle without wb_valid and clear on each capture.
REQ-024 If the completing capture and idle_cnt reaching TIMEOUT_CYC occur in the same cycle, DONE SHALL win.
REQ-025 done and timeout SHALL go high the cycle after the triggering edge; capture latency SHALL be 1 cycle, so rd_data reflects a write on the next cycle.
REQ-026 The read index SHALL map as physical = (wr_ptr - fill + rd_addr) mod DEPTH; when rd_addr >= fill, rd_data SHALL be 0.

Reset
REQ-027 rst SHALL asynchronously force: state=IDLE, cap_cnt=0, fill=0, wr_ptr=0, idle_cnt=0, overflow=0, done=0, timeout=0, signature=0.
REQ-028 Buffer contents SHALL NOT need reset; rd_data SHALL be 0 after reset because fill=0.
REQ-029 rst asserted mid-RUN SHALL abort capture; state stays IDLE until start.

Configuration
REQ-030 With macro WB_TRACE_SIGNATURE_EN defined, output sig [DATA_W] SHALL exist and update on each capture as sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ wb_data.
REQ-031 Without WB_TRACE_SIGNATURE_EN, the sig port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 The state encoding constants and the 16-bit counter width SHALL reside in the shared package wb_trace_pkg.
REQ-033 The buffer SHALL be a sub-module wb_trace_ram: DEPTH x DATA_W, one synchronous write port and one asynchronous read port; the FSM, pointers and counters stay in the top module.

Verification
REQ-034 rst, then start, then 8 back-to-back wb_valid with data 1..8 (EXPECT_CNT=8) -> DONE the cycle after the 8th capture; cap_cnt=8; rd_addr 0..7 reads 1..8; overflow=0.
REQ-035 DEPTH=4, EXPECT_CNT=8, data 10..17 -> fill=4, overflow=1, rd_addr 0..3 reads 14..17.
REQ-036 start, 3 captures, then 64 idle cycles -> TIMEOUT one cycle later; cap_cnt=3.
REQ-037 TIMEOUT_CYC=4: the 8th capture arrives in the cycle idle_cnt would reach 4 -> DONE and timeout=0.
REQ-038 rst pulse mid-RUN after 5 captures -> all outputs at reset values; start, then 8 captures -> normal DONE.
REQ-039 With WB_TRACE_SIGNATURE_EN, DATA_W=8, data 0x01, 0x02 -> sig=0x00 after start, then 0x01, then 0x00.
